aes128_iter_core: RTL and testbench

AES128_ITER_CORE -- requirements
Module: aes128_iter_core

---
 rtl/aes_pkg.sv | 26 ++
 rtl/aes128_key_step.sv | 14 +
 rtl/aes_round_ops.sv | 44 ++++
 rtl/aes128_iter_core.sv | 79 +++++++
 tb/tb_aes128_iter_core.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants, types, S-box, rcon table and GF(2^8) helpers.
package aes_pkg;
    localparam int NR = 10;
    typedef logic [127:0] block_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [7:0] RCON [NR] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[2047 - 8*int'(b) -: 8];
    endfunction
    // Rounds outside 1..NR never reach the datapath result, so they map to zero.
    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        return (r != 4'd0 && r <= 4'(NR)) ? RCON[r - 4'd1] : 8'h00;
    endfunction
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction
endpackage

// File: rtl/aes128_key_step.sv
// aes128_key_step: one AES-128 key-expansion step (RotWord, SubWord, rcon, word chaining).
module aes128_key_step import aes_pkg::*; (
    input  logic [127:0] key,
    input  logic [7:0]   rcon,
    output logic [127:0] next_key
);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2;
    assign {w0, w1, w2, w3} = key;
    assign t = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign next_key = {n0, n1, n2, w3 ^ n2};
endmodule

// File: rtl/aes_round_ops.sv
// aes_round_ops: SubBytes, ShiftRows, MixColumns and AddRoundKey transforms.
// Byte k of the block sits at bits [127-8k -: 8]; byte k is row k%4, column k/4.
module sub_bytes import aes_pkg::*; (
    input  logic [127:0] state,
    output logic [127:0] result
);
    for (genvar i = 0; i < 16; i++) begin : g_b
        assign result[8*i +: 8] = sbox(state[8*i +: 8]);
    end
endmodule

module shift_rows (
    input  logic [127:0] state,
    output logic [127:0] result
);
    for (genvar c = 0; c < 4; c++) begin : g_c
        for (genvar r = 0; r < 4; r++) begin : g_r
            assign result[127 - 8*(4*c + r) -: 8] = state[127 - 8*(4*((c + r) % 4) + r) -: 8];
        end
    end
endmodule

module mix_columns import aes_pkg::*; (
    input  logic [127:0] state,
    output logic [127:0] result
);
    for (genvar c = 0; c < 4; c++) begin : g_c
        logic [7:0] a0, a1, a2, a3;
        assign {a0, a1, a2, a3} = state[127 - 32*c -: 32];
        assign result[127 - 32*c -: 32] = {
            xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
endmodule

module add_round_key (
    input  logic [127:0] state,
    input  logic [127:0] key,
    output logic [127:0] result
);
    assign result = state ^ key;
endmodule

// File: rtl/aes128_iter_core.sv
// aes128_iter_core: iterative AES-128 encryptor, UNROLL rounds per clock, on-the-fly key expansion.
// Define AES_ABORT_EN to add the abort input.
module aes128_iter_core import aes_pkg::*; #(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef AES_ABORT_EN
    input  logic         abort,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
        $error("aes128_iter_core: UNROLL must be 1, 2, 5 or 10");
    end
    state_t state, state_nx;
    logic [3:0] rnd_cnt;
    block_t state_reg, round_key;
    block_t s [UNROLL+1];
    block_t k [UNROLL+1];
    logic kill, accept, last;
`ifdef AES_ABORT_EN
    assign kill = abort && state != IDLE;
`else
    assign kill = 1'b0;
`endif
    assign in_ready  = state == IDLE || (state == DONE && out_ready);
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    assign accept    = in_valid && in_ready && !kill;
    assign last      = state == RUN && rnd_cnt == 4'(NR + 1 - UNROLL);
    assign s[0] = state_reg;
    assign k[0] = round_key;
    for (genvar i = 0; i < UNROLL; i++) begin : g_rnd
        logic [3:0] r;
        block_t sb, sr, mc;
        assign r = rnd_cnt + 4'(i);
        aes128_key_step u_ks (.key(k[i]), .rcon(rcon_of(r)), .next_key(k[i+1]));
        sub_bytes u_sb (.state(s[i]), .result(sb));
        shift_rows u_sr (.state(sb), .result(sr));
        mix_columns u_mc (.state(sr), .result(mc));
        add_round_key u_ark (.state(r == 4'(NR) ? sr : mc), .key(k[i+1]), .result(s[i+1]));
    end
    always_comb begin
        state_nx = state;
        if (kill) state_nx = IDLE;
        else if (accept) state_nx = RUN;
        else if (last) state_nx = DONE;
        else if (state == DONE && out_ready) state_nx = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rnd_cnt   <= '0;
            state_reg <= '0;
            round_key <= '0;
            out_data  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                state_reg <= in_data ^ in_key;
                round_key <= in_key;
                rnd_cnt   <= 4'd1;
            end else if (state == RUN && !kill) begin
                state_reg <= s[UNROLL];
                round_key <= k[UNROLL];
                rnd_cnt   <= rnd_cnt + 4'(UNROLL);
                if (last) out_data <= s[UNROLL];
            end
        end
    end
endmodule

// File: tb/tb_aes128_iter_core.sv
// tb_aes128_iter_core: directed FIPS-197 vectors against all four legal UNROLL builds in parallel.
module tb_aes128_iter_core;
    localparam logic [127:0] KA = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PA = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CA = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam int UN [4] = '{1, 2, 5, 10};
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [127:0] in_data = '0, in_key = '0;
    logic [3:0] ir, ov, bz;
    logic [127:0] od [4];
`ifdef AES_ABORT_EN
    logic abort = 1'b0;
`endif
    int checks = 0, failures = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 4; g++) begin : g_dut
        aes128_iter_core #(.UNROLL(UN[g])) u_dut (
            .clk(clk),
            .rst_n(rst_n),
`ifdef AES_ABORT_EN
            .abort(abort),
`endif
            .in_valid(in_valid),
            .in_ready(ir[g]),
            .in_data(in_data),
            .in_key(in_key),
            .out_valid(ov[g]),
            .out_ready(out_ready),
            .out_data(od[g]),
            .busy(bz[g])
        );
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [127:0] pt, input logic [127:0] key);
        in_data = pt;
        in_key = key;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data = '0;
        in_key = '0;
    endtask
    task automatic wait_done(output int n);
        n = 0;
        while (!ov[0] && n < 20) begin
            tick();
            n++;
        end
    endtask
    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask
    task automatic test_reset();
        tick();
        tick();
        checks++; if (ov !== 4'h0) begin failures++; $display("FAIL reset_out_valid: got %b want 0000", ov); end
        checks++; if (bz !== 4'h0) begin failures++; $display("FAIL reset_busy: got %b want 0000", bz); end
        checks++; if (od[0] !== '0 || od[3] !== '0) begin failures++; $display("FAIL reset_out_data: got %h / %h want 0", od[0], od[3]); end
        rst_n = 1'b1;
        tick();
        checks++; if (ir !== 4'hf) begin failures++; $display("FAIL reset_in_ready: got %b want 1111", ir); end
    endtask
    task automatic test_unroll();
        int lat [4];
        for (int g = 0; g < 4; g++) lat[g] = -1;
        send(PA, KA);
        for (int c = 1; c <= 12; c++) begin
            tick();
            for (int g = 0; g < 4; g++) if (ov[g] && lat[g] < 0) lat[g] = c;
        end
        for (int g = 0; g < 4; g++) begin
            checks++; if (lat[g] != 10 / UN[g]) begin failures++; $display("FAIL latency_u%0d: got %0d want %0d", UN[g], lat[g], 10 / UN[g]); end
            checks++; if (od[g] !== CA) begin failures++; $display("FAIL data_u%0d: got %h want %h", UN[g], od[g], CA); end
        end
        release_out();
        checks++; if (ov !== 4'h0 || bz !== 4'h0) begin failures++; $display("FAIL release_idle: got ov=%b busy=%b want 0000", ov, bz); end
    endtask
    task automatic test_fips_b();
        int n;
        send(PB, KB);
        wait_done(n);
        checks++; if (n != 10) begin failures++; $display("FAIL fips_b_latency: got %0d want 10", n); end
        checks++; if (od !== '{CB, CB, CB, CB}) begin failures++; $display("FAIL fips_b_data: got %h want %h", od[0], CB); end
        release_out();
    endtask
    task automatic test_back_to_back();
        int n;
        send(PA, KA);
        wait_done(n);
        checks++; if (od[0] !== CA) begin failures++; $display("FAIL b2b_first: got %h want %h", od[0], CA); end
        for (int c = 0; c < 7; c++) begin
            tick();
            checks++;
            if (od[0] !== CA || ir[0] !== 1'b0 || bz[0] !== 1'b1 || ov[0] !== 1'b1) begin
                failures++;
                $display("FAIL hold_c%0d: got data=%h in_ready=%b busy=%b out_valid=%b want %h 0 1 1", c, od[0], ir[0], bz[0], ov[0], CA);
            end
        end
        in_data = PB;
        in_key = KB;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++; if (ov[0] !== 1'b0 || bz[0] !== 1'b1) begin failures++; $display("FAIL b2b_run: got out_valid=%b busy=%b want 0 1", ov[0], bz[0]); end
        wait_done(n);
        checks++; if (n != 10) begin failures++; $display("FAIL b2b_latency: got %0d want 10", n); end
        checks++; if (od[0] !== CB) begin failures++; $display("FAIL b2b_second: got %h want %h", od[0], CB); end
        release_out();
    endtask
    task automatic test_run_ignore();
        int n;
        send(PA, KA);
        tick();
        tick();
        in_data = PB;
        in_key = KB;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_done(n);
        checks++; if (n + 3 != 10) begin failures++; $display("FAIL ignore_latency: got %0d want 10", n + 3); end
        checks++; if (od[0] !== CA) begin failures++; $display("FAIL ignore_data: got %h want %h", od[0], CA); end
        release_out();
    endtask
    task automatic test_reset_mid();
        int n;
        logic seen;
        send(PA, KA);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #2;
        checks++; if (ov !== 4'h0 || bz !== 4'h0) begin failures++; $display("FAIL midreset_idle: got ov=%b busy=%b want 0000", ov, bz); end
        checks++; if (ir !== 4'hf) begin failures++; $display("FAIL midreset_in_ready: got %b want 1111", ir); end
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            seen |= ov[0];
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midreset_no_output: got out_valid=%b want 0", seen); end
        send(PA, KA);
        wait_done(n);
        checks++; if (n != 10 || od[0] !== CA) begin failures++; $display("FAIL midreset_next: got lat=%0d data=%h want 10 %h", n, od[0], CA); end
        release_out();
    endtask
`ifdef AES_ABORT_EN
    task automatic test_abort();
        int n;
        logic seen;
        send(PA, KA);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (ov !== 4'h0 || bz !== 4'h0 || ir !== 4'hf) begin failures++; $display("FAIL abort_run: got ov=%b busy=%b in_ready=%b want 0000 0000 1111", ov, bz, ir); end
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            seen |= ov[0];
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_output: got out_valid=%b want 0", seen); end
        send(PA, KA);
        wait_done(n);
        checks++; if (od[0] !== CA) begin failures++; $display("FAIL abort_pre_done: got %h want %h", od[0], CA); end
        abort = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = PB;
        in_key = KB;
        tick();
        abort = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b0;
        checks++; if (ov !== 4'h0 || bz !== 4'h0) begin failures++; $display("FAIL abort_done: got ov=%b busy=%b want 0000 0000", ov, bz); end
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            seen |= bz[0] | ov[0];
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_accept: got busy/out_valid=%b want 0", seen); end
    endtask
`endif
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    initial begin
        test_reset();
        test_unroll();
        test_fips_b();
        test_back_to_back();
        test_run_ignore();
        test_reset_mid();
`ifdef AES_ABORT_EN
        test_abort();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
